// File: rtl/seq_sub_slice.sv
// seq_sub_slice: multi-cycle subtractor, Diff = A - B - Bin.
// Each RUN cycle subtracts one SLICE-bit slice, starting with the LSB slice.
// The borrow between slices is held in a register.
// Start/Ready/Done handshake. Results stay stable until the next accepted Start.
module seq_sub_slice #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             Ready,
  output logic             Done,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout,
  output logic             Zero,
  output logic             Ovf
);

  localparam int N     = WIDTH / SLICE;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // One slice of A - B - borrow, computed as A + ~B + ~borrow.
  // The carry out of this sum is the inverted borrow out.
  function automatic logic [SLICE:0] slice_sub(
    input logic [SLICE-1:0] a,
    input logic [SLICE-1:0] b,
    input logic             borrow
  );
    return {1'b0, a} + {1'b0, ~b} + {{SLICE{1'b0}}, ~borrow};
  endfunction

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             borrow_q, borrow_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;

  logic [SLICE:0]   slice_res;
  int               base;

  // Next-state, operand capture and per-slice datapath.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    borrow_d  = borrow_q;
    idx_d     = idx_q;
    diff_d    = diff_q;
    bout_d    = bout_q;
    zero_d    = zero_q;
    ovf_d     = ovf_q;
    ready_d   = ready_q;
    done_d    = 1'b0;

    base      = int'(idx_q) * SLICE;
    slice_res = slice_sub(a_q[base +: SLICE], b_q[base +: SLICE], borrow_q);

    case (state_q)
      S_IDLE: begin
        if (Start && ready_q) begin
          state_d  = S_RUN;
          a_d      = A;
          b_d      = B;
          borrow_d = Bin;
          idx_d    = '0;
          diff_d   = '0;
          bout_d   = 1'b0;
          zero_d   = 1'b0;
          ovf_d    = 1'b0;
          ready_d  = 1'b0;
        end
      end
      S_RUN: begin
        diff_d[base +: SLICE] = slice_res[SLICE-1:0];
        borrow_d              = ~slice_res[SLICE];
        if (idx_q == LAST_IDX) begin
          // The flags come from the completed difference, which includes the slice being written now.
          state_d = S_DONE;
          bout_d  = ~slice_res[SLICE];
          zero_d  = (diff_d == '0);
          ovf_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff_d[WIDTH-1] != a_q[WIDTH-1]);
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      S_DONE: begin
        // Done is registered at this exit edge, so it pulses in the first IDLE cycle, when Ready is also high.
        state_d = S_IDLE;
        ready_d = 1'b1;
        done_d  = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  // Control and result registers. Reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      borrow_q <= 1'b0;
      idx_q    <= '0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      borrow_q <= borrow_d;
      idx_q    <= idx_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
    end
  end

  // Operand holding registers. They are only read in RUN, so they need no reset.
  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
  end

  assign Ready = ready_q;
  assign Done  = done_q;
  assign Diff  = diff_q;
  assign Bout  = bout_q;
  assign Zero  = zero_q;
  assign Ovf   = ovf_q;

endmodule

// File: tb/tb_seq_sub_slice.sv
// Testbench for seq_sub_slice with WIDTH=32 and SLICE=8.
// The reference model computes A - B - Bin with plain wide arithmetic.
module tb_seq_sub_slice;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         Start;
  logic [W-1:0] A, B;
  logic         Bin;
  logic         Ready, Done;
  logic [W-1:0] Diff;
  logic         Bout, Zero, Ovf;

  int n_checks = 0;
  int n_pass   = 0;

  seq_sub_slice #(.WIDTH(W), .SLICE(8)) dut (
    .clk(clk), .rst(rst), .Start(Start), .A(A), .B(B), .Bin(Bin),
    .Ready(Ready), .Done(Done), .Diff(Diff), .Bout(Bout), .Zero(Zero), .Ovf(Ovf)
  );

  always #5 clk = ~clk;

  // Reference result as {Diff, Bout, Zero, Ovf}.
  function automatic logic [W+2:0] model(input logic [W-1:0] a, b, input logic bin);
    logic [W:0]   wide;
    logic [W-1:0] d;
    logic         bo, z, ov;
    wide = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
    d    = wide[W-1:0];
    bo   = wide[W];
    z    = (d == '0);
    ov   = (a[W-1] != b[W-1]) && (d[W-1] != a[W-1]);
    return {d, bo, z, ov};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts one operation and waits a bounded time for Done. lat is -1 on timeout.
  task automatic do_op(input logic [W-1:0] a, b, input logic bin,
                       output logic [W+2:0] got, output int lat, output logic rdy0);
    rdy0  = Ready;
    A     = a;
    B     = b;
    Bin   = bin;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    lat   = -1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (Done === 1'b1) begin
        lat = k;
        break;
      end
    end
    got = {Diff, Bout, Zero, Ovf};
  endtask

  task automatic test_reset();
    rst = 1'b1; Start = 1'b0; A = '0; B = '0; Bin = 1'b0;
    tick(); tick();
    n_checks++;
    if ({Ready, Done, Diff, Bout, Zero, Ovf} !== {1'b1, 1'b0, {W{1'b0}}, 3'b000})
      $display("FAIL reset_state: got Ready=%b Done=%b Diff=%h flags=%b%b%b, want 1 0 0 000",
               Ready, Done, Diff, Bout, Zero, Ovf);
    else n_pass++;
    rst = 1'b0;
    tick();
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] d;
    logic         bo;
    logic         z;
    logic         ov;
  } vec_t;

  task automatic test_directed();
    vec_t        v[6];
    logic [W+2:0] got;
    int          lat;
    logic        rdy0;
    v[0] = '{32'h00000005, 32'h00000003, 1'b0, 32'h00000002, 1'b0, 1'b0, 1'b0};
    v[1] = '{32'h00000100, 32'h00000001, 1'b0, 32'h000000FF, 1'b0, 1'b0, 1'b0};
    v[2] = '{32'h00000000, 32'h00000001, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0};
    v[3] = '{32'h80000000, 32'h00000001, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b1};
    v[4] = '{32'h12345678, 32'h12345678, 1'b0, 32'h00000000, 1'b0, 1'b1, 1'b0};
    v[5] = '{32'h12345678, 32'h12345678, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) begin
      do_op(v[i].a, v[i].b, v[i].bin, got, lat, rdy0);
      n_checks++;
      if (lat !== 5 || rdy0 !== 1'b1)
        $display("FAIL directed_latency[%0d]: got lat=%0d ready=%b, want 5 1", i, lat, rdy0);
      else n_pass++;
      n_checks++;
      if (got !== {v[i].d, v[i].bo, v[i].z, v[i].ov})
        $display("FAIL directed_result[%0d]: got %h/%b%b%b, want %h/%b%b%b", i,
                 got[W+2:3], got[2], got[1], got[0], v[i].d, v[i].bo, v[i].z, v[i].ov);
      else n_pass++;
      tick();
      n_checks++;
      if (Done !== 1'b0)
        $display("FAIL directed_done_pulse[%0d]: got Done=%b, want 0", i, Done);
      else n_pass++;
    end
  endtask

  task automatic test_hold();
    logic [W+2:0] got, exp;
    int          lat;
    logic        rdy0;
    exp = model(32'hDEADBEEF, 32'h0BADF00D, 1'b1);
    do_op(32'hDEADBEEF, 32'h0BADF00D, 1'b1, got, lat, rdy0);
    for (int i = 0; i < 4; i++) begin
      A = $urandom; B = $urandom; Bin = 1'($urandom);
      tick();
      n_checks++;
      if ({Diff, Bout, Zero, Ovf, Ready, Done} !== {exp, 2'b10})
        $display("FAIL hold[%0d]: got %h/%b%b%b R=%b D=%b, want %h/%b%b%b R=1 D=0", i,
                 Diff, Bout, Zero, Ovf, Ready, Done, exp[W+2:3], exp[2], exp[1], exp[0]);
      else n_pass++;
    end
  endtask

  task automatic test_start_ignored();
    logic [W+2:0] exp;
    int          lat;
    exp = model(32'h0000F000, 32'h00001234, 1'b0);
    A = 32'h0000F000; B = 32'h00001234; Bin = 1'b0; Start = 1'b1;
    tick();
    Start = 1'b0;
    tick();
    A = 32'h00000000; B = 32'hFFFFFFFF; Bin = 1'b1; Start = 1'b1;
    n_checks++;
    if (Ready !== 1'b0) $display("FAIL run_ready: got Ready=%b, want 0", Ready);
    else n_pass++;
    tick();
    Start = 1'b0;
    lat = -1;
    for (int k = 3; k <= 20; k++) begin
      A = $urandom; B = $urandom; Bin = 1'($urandom);
      tick();
      if (Done === 1'b1) begin
        lat = k;
        break;
      end
    end
    n_checks++;
    if (lat !== 5 || {Diff, Bout, Zero, Ovf} !== exp)
      $display("FAIL start_ignored: got lat=%0d %h/%b%b%b, want lat=5 %h/%b%b%b", lat,
               Diff, Bout, Zero, Ovf, exp[W+2:3], exp[2], exp[1], exp[0]);
    else n_pass++;
    tick();
  endtask

  task automatic test_reset_abort();
    logic seen_done;
    A = 32'h11111111; B = 32'h00000000; Bin = 1'b0; Start = 1'b1;
    tick();
    Start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if ({Ready, Done, Diff, Bout, Zero, Ovf} !== {1'b1, 1'b0, {W{1'b0}}, 3'b000})
      $display("FAIL abort_state: got Ready=%b Done=%b Diff=%h flags=%b%b%b, want 1 0 0 000",
               Ready, Done, Diff, Bout, Zero, Ovf);
    else n_pass++;
    seen_done = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (Done === 1'b1) seen_done = 1'b1;
    end
    n_checks++;
    if (seen_done !== 1'b0 || Diff !== '0)
      $display("FAIL abort_no_done: got done_seen=%b Diff=%h, want 0 0", seen_done, Diff);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [W+2:0] got, exp;
    logic [W-1:0] a, b;
    logic         bin;
    int           lat, gap;
    logic         rdy0;
    for (int i = 0; i < 10000; i++) begin
      case ($urandom % 4)
        0:       begin a = $urandom; b = a; end
        1:       begin a = $urandom % 4; b = $urandom % 4; end
        default: begin a = $urandom; b = $urandom; end
      endcase
      bin = 1'($urandom);
      exp = model(a, b, bin);
      do_op(a, b, bin, got, lat, rdy0);
      n_checks++;
      if (lat !== 5 || rdy0 !== 1'b1 || got !== exp)
        $display("FAIL random[%0d] A=%h B=%h Bin=%b: got lat=%0d rdy=%b %h/%b%b%b, want lat=5 rdy=1 %h/%b%b%b",
                 i, a, b, bin, lat, rdy0, got[W+2:3], got[2], got[1], got[0],
                 exp[W+2:3], exp[2], exp[1], exp[0]);
      else n_pass++;
      gap = ($urandom % 4 == 0) ? int'(1 + $urandom % 2) : 0;
      repeat (gap) tick();
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_hold();
    test_start_ignored();
    test_reset_abort();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
